// File: rtl/udm_lfsr_slave.sv
// rtl/udm_lfsr_slave.sv - memory-mapped 32-bit Galois LFSR accelerator on the UDM bus
//
// Host loads SEED and STEPS, writes CTRL.start, and the block advances the LFSR
// one step per clock until STEPS steps are done. Status and result stay readable
// at all times. The block only responds inside its 32-byte window at BASE_ADDR.
//
// Ports:
//   clk_i, rst_i       clock, asynchronous active-high reset
//   bus_req_i          bus request
//   bus_we_i           1 = write, 0 = read
//   bus_addr_bi        byte address
//   bus_be_bi          byte enables (SEED/STEPS writes only)
//   bus_wdata_bi       write data
//   bus_ack_o          request accepted (combinational, same cycle)
//   bus_resp_o         read response valid, one cycle after the accepted read
//   bus_rdata_bo       read data, zero whenever bus_resp_o is low
//   done_o             high while the FSM sits in DONE
//
// Register map (offset):
//   0x00 SEED RW, 0x04 STEPS RW, 0x08 CTRL W (bit0 start, bit1 clr_done),
//   0x0C STATUS R (bit0 busy, bit1 done), 0x10 RESULT R, 0x14 COUNT R,
//   0x18/0x1C read as zero.

module udm_lfsr_slave #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0100,
    parameter logic [31:0] POLY      = 32'hB4BC_D35C
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        bus_req_i,
    input  logic        bus_we_i,
    input  logic [31:0] bus_addr_bi,
    input  logic [3:0]  bus_be_bi,
    input  logic [31:0] bus_wdata_bi,
    output logic        bus_ack_o,
    output logic        bus_resp_o,
    output logic [31:0] bus_rdata_bo,
    output logic        done_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } fsm_t;

    localparam logic [2:0] W_SEED   = 3'd0;
    localparam logic [2:0] W_STEPS  = 3'd1;
    localparam logic [2:0] W_CTRL   = 3'd2;
    localparam logic [2:0] W_STATUS = 3'd3;
    localparam logic [2:0] W_RESULT = 3'd4;
    localparam logic [2:0] W_COUNT  = 3'd5;

    fsm_t        fsm_q, fsm_d;
    logic [31:0] seed_q, seed_d;
    logic [31:0] steps_q, steps_d;
    logic [31:0] lfsr_q, lfsr_d;
    logic [31:0] count_q, count_d;
    logic        resp_q, resp_d;
    logic [31:0] rdata_q, rdata_d;

    logic        sel;
    logic        wr_en;
    logic        rd_en;
    logic [2:0]  word;
    logic        busy;
    logic        start_wr;
    logic        clr_wr;
    logic [31:0] rd_mux;
    logic        unused_addr_lsb;

    // Word index inside the window; byte lane bits do not select registers.
    assign word            = bus_addr_bi[4:2];
    assign unused_addr_lsb = ^bus_addr_bi[1:0];

    assign sel       = (bus_addr_bi[31:5] == BASE_ADDR[31:5]);
    // Held low during reset so nothing is accepted while registers are cleared.
    assign bus_ack_o = bus_req_i & sel & ~rst_i;
    assign wr_en     = bus_ack_o & bus_we_i;
    assign rd_en     = bus_ack_o & ~bus_we_i;

    assign busy      = (fsm_q == S_RUN);
    assign start_wr  = wr_en & (word == W_CTRL) & bus_wdata_bi[0];
    assign clr_wr    = wr_en & (word == W_CTRL) & bus_wdata_bi[1];

    function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                r[8*i +: 8] = new_v[8*i +: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
    endfunction

    // Configuration registers are frozen while a run is in progress.
    always_comb begin
        seed_d  = seed_q;
        steps_d = steps_q;
        if (wr_en && !busy) begin
            if (word == W_SEED) begin
                seed_d = be_merge(seed_q, bus_wdata_bi, bus_be_bi);
            end
            if (word == W_STEPS) begin
                steps_d = be_merge(steps_q, bus_wdata_bi, bus_be_bi);
            end
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        lfsr_d  = lfsr_q;
        count_d = count_q;
        case (fsm_q)
            S_IDLE, S_DONE: begin
                if (start_wr) begin
                    // All-zero is the LFSR lock-up state, so it is replaced by 1.
                    lfsr_d  = (seed_q == 32'd0) ? 32'd1 : seed_q;
                    count_d = steps_q;
                    fsm_d   = (steps_q == 32'd0) ? S_DONE : S_RUN;
                end else if (clr_wr && (fsm_q == S_DONE)) begin
                    fsm_d = S_IDLE;
                end
            end
            S_RUN: begin
                lfsr_d = lfsr_step(lfsr_q);
                if (count_q != 32'd0) begin
                    count_d = count_q - 32'd1;
                end
                if (count_q <= 32'd1) begin
                    fsm_d = S_DONE;
                end
            end
            default: fsm_d = S_IDLE;
        endcase
    end

    always_comb begin
        rd_mux = 32'd0;
        case (word)
            W_SEED:   rd_mux = seed_q;
            W_STEPS:  rd_mux = steps_q;
            W_STATUS: rd_mux = {30'd0, (fsm_q == S_DONE), busy};
            W_RESULT: rd_mux = lfsr_q;
            W_COUNT:  rd_mux = count_q;
            default:  rd_mux = 32'd0;
        endcase
    end

    // Read data is only driven alongside resp so idle cycles show zero.
    always_comb begin
        resp_d  = rd_en;
        rdata_d = rd_en ? rd_mux : 32'd0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fsm_q   <= S_IDLE;
            seed_q  <= 32'd0;
            steps_q <= 32'd0;
            lfsr_q  <= 32'd0;
            count_q <= 32'd0;
            resp_q  <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            fsm_q   <= fsm_d;
            seed_q  <= seed_d;
            steps_q <= steps_d;
            lfsr_q  <= lfsr_d;
            count_q <= count_d;
            resp_q  <= resp_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus_resp_o   = resp_q;
    assign bus_rdata_bo = rdata_q;
    assign done_o       = (fsm_q == S_DONE);

endmodule

// File: tb/tb_udm_lfsr_slave.sv
// tb/tb_udm_lfsr_slave.sv - self-checking bench for udm_lfsr_slave

module tb_udm_lfsr_slave;

    localparam logic [31:0] BASE = 32'h0000_0100;
    localparam logic [31:0] POLY = 32'hB4BC_D35C;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        bus_req_i = 1'b0;
    logic        bus_we_i = 1'b0;
    logic [31:0] bus_addr_bi = 32'd0;
    logic [3:0]  bus_be_bi = 4'd0;
    logic [31:0] bus_wdata_bi = 32'd0;
    logic        bus_ack_o;
    logic        bus_resp_o;
    logic [31:0] bus_rdata_bo;
    logic        done_o;

    udm_lfsr_slave #(.BASE_ADDR(BASE), .POLY(POLY)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .bus_req_i    (bus_req_i),
        .bus_we_i     (bus_we_i),
        .bus_addr_bi  (bus_addr_bi),
        .bus_be_bi    (bus_be_bi),
        .bus_wdata_bi (bus_wdata_bi),
        .bus_ack_o    (bus_ack_o),
        .bus_resp_o   (bus_resp_o),
        .bus_rdata_bo (bus_rdata_bo),
        .done_o       (done_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: registers plus the cycle of the last accepted start. Everything
    // else is derived from how many cycles have elapsed since that start.
    logic [31:0] m_seed = 0, m_steps = 0, m_seed_ld = 0;
    bit          m_started = 0, m_cleared = 1;
    int          m_T = 0, m_N = 0;
    int          exp_cyc[$];
    logic [31:0] exp_dat[$];

    function automatic logic [31:0] lfsr_n(input logic [31:0] s0, input int n);
        logic [31:0] s;
        s = s0;
        for (int i = 0; i < n; i++) s = s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
        return s;
    endfunction

    function automatic bit in_win(input logic [31:0] a);
        return (a >= BASE) && (a <= BASE + 32'd31);
    endfunction

    function automatic int m_sd(input int c);
        int k;
        k = c - m_T - 1;
        if (k < 0) k = 0;
        if (k > m_N) k = m_N;
        return k;
    endfunction

    function automatic bit m_busy(input int c);
        return m_started && !m_cleared && (c - m_T >= 1) && (c - m_T <= m_N);
    endfunction

    function automatic bit m_done(input int c);
        return m_started && !m_cleared && (c - m_T >= m_N + 1);
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a, input int c);
        logic [31:0] off;
        off = (a - BASE) >> 2;
        case (off)
            0: return m_seed;
            1: return m_steps;
            3: return {30'd0, m_done(c), m_busy(c)};
            4: return m_started ? lfsr_n(m_seed_ld, m_sd(c)) : 32'd0;
            5: return m_started ? 32'(m_N - m_sd(c)) : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = be[i / 8] ? n[i] : o[i];
        return r;
    endfunction

    // One bus transfer; entered and left 1 time unit after a rising edge.
    task automatic op(input bit we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        int c;
        bus_req_i = 1; bus_we_i = we; bus_addr_bi = a; bus_wdata_bi = d; bus_be_bi = be;
        c = cyc;
        if (!we && in_win(a)) begin
            exp_cyc.push_back(c + 1);
            exp_dat.push_back(m_read(a, c));
        end
        @(posedge clk_i);
        if (we && in_win(a)) begin
            case ((a - BASE) >> 2)
                0: if (!m_busy(c)) m_seed = merge(m_seed, d, be);
                1: if (!m_busy(c)) m_steps = merge(m_steps, d, be);
                2: begin
                    if (d[0] && !m_busy(c)) begin
                        m_started = 1; m_cleared = 0; m_T = c; m_N = int'(m_steps);
                        m_seed_ld = (m_seed == 0) ? 32'd1 : m_seed;
                    end else if (d[1] && m_done(c)) begin
                        m_cleared = 1;
                    end
                end
                default: ;
            endcase
        end
        #1;
        bus_req_i = 0; bus_we_i = 0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        op(1, a, d, 4'hF);
    endtask

    task automatic rd(input logic [31:0] a);
        op(0, a, 32'd0, 4'h0);
    endtask

    task automatic rd_lit(input string name, input logic [31:0] a, input logic [31:0] lit);
        op(0, a, 32'd0, 4'h0);
        chk(name, bus_rdata_bo, lit);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // Continuous comparison of every output against the model.
    always @(negedge clk_i) begin
        chk("ack", {31'd0, bus_ack_o}, {31'd0, bus_req_i && !rst_i && in_win(bus_addr_bi)});
        chk("done_o", {31'd0, done_o}, {31'd0, !rst_i && m_done(cyc)});
        if (exp_cyc.size() > 0 && exp_cyc[0] == cyc) begin
            chk("resp", {31'd0, bus_resp_o}, 32'd1);
            chk("rdata", bus_rdata_bo, exp_dat[0]);
            void'(exp_cyc.pop_front());
            void'(exp_dat.pop_front());
        end else begin
            chk("resp_idle", {31'd0, bus_resp_o}, 32'd0);
            chk("rdata_idle", bus_rdata_bo, 32'd0);
        end
    end

    int t0;
    int done_at;

    initial begin
        // Model pinned against hand-computed values.
        chk("model_1step", lfsr_n(32'd1, 1), 32'hB4BC_D35C);
        chk("model_2step", lfsr_n(32'd1, 2), 32'h5A5E_69AE);

        repeat (2) @(posedge clk_i);
        #1 rst_i = 0;

        // Reset values
        rd_lit("rst_seed",   BASE + 32'h00, 32'd0);
        rd_lit("rst_status", BASE + 32'h0C, 32'd0);
        rd_lit("rst_result", BASE + 32'h10, 32'd0);
        rd_lit("rst_count",  BASE + 32'h14, 32'd0);

        // Byte enables
        wr(BASE, 32'h1122_3344);
        op(1, BASE, 32'hAABB_CCDD, 4'b0101);
        rd_lit("be_seed", BASE, 32'h11BB_33DD);

        // Single step: done_o high two cycles after the start write
        wr(BASE + 32'h00, 32'd1);
        wr(BASE + 32'h04, 32'd1);
        wr(BASE + 32'h08, 32'd1);
        chk("step1_done_early", {31'd0, done_o}, 32'd0);
        idle(1);
        chk("step1_done", {31'd0, done_o}, 32'd1);
        rd_lit("step1_result", BASE + 32'h10, 32'hB4BC_D35C);
        rd_lit("step1_count",  BASE + 32'h14, 32'd0);

        // Double step, restarted directly from DONE
        wr(BASE + 32'h04, 32'd2);
        wr(BASE + 32'h08, 32'd1);
        idle(3);
        rd_lit("step2_result", BASE + 32'h10, 32'h5A5E_69AE);
        wr(BASE + 32'h08, 32'd2);
        rd_lit("clr_status", BASE + 32'h0C, 32'd0);

        // Zero seed / zero steps
        wr(BASE + 32'h00, 32'd0);
        wr(BASE + 32'h04, 32'd0);
        wr(BASE + 32'h08, 32'd1);
        rd_lit("zero_status", BASE + 32'h0C, 32'd2);
        rd_lit("zero_result", BASE + 32'h10, 32'd1);
        rd_lit("zero_count",  BASE + 32'h14, 32'd0);
        wr(BASE + 32'h08, 32'd2);
        rd_lit("zero_clr", BASE + 32'h0C, 32'd0);

        // Busy protection
        wr(BASE + 32'h00, 32'd1);
        wr(BASE + 32'h04, 32'd100);
        t0 = cyc;
        wr(BASE + 32'h08, 32'd1);
        idle(9);
        wr(BASE + 32'h00, 32'hFFFF_FFFF);
        wr(BASE + 32'h08, 32'd1);
        rd_lit("busy_count", BASE + 32'h14, 32'd89);
        rd_lit("busy_seed",  BASE + 32'h00, 32'd1);
        done_at = -1;
        for (int i = 0; i < 200; i++) begin
            if (done_o) begin
                done_at = cyc;
                break;
            end
            idle(1);
        end
        chk("busy_done_cycle", 32'(done_at), 32'(t0 + 101));
        rd(BASE + 32'h10);

        // Bus protocol: single read, back-to-back reads, out-of-window write
        rd(BASE + 32'h04);
        rd(BASE + 32'h00);
        rd(BASE + 32'h0C);
        idle(1);
        wr(32'h0000_0200, 32'h5555_5555);
        wr(32'h0000_0208, 32'd1);
        rd_lit("oow_seed",   BASE + 32'h00, 32'd1);
        rd_lit("oow_status", BASE + 32'h0C, 32'd2);

        // start and clr_done together: start wins
        wr(BASE + 32'h04, 32'd3);
        wr(BASE + 32'h08, 32'd3);
        rd_lit("both_status", BASE + 32'h0C, 32'd1);
        idle(4);
        rd(BASE + 32'h10);

        // Reset in the middle of a long run
        wr(BASE + 32'h04, 32'd1000);
        wr(BASE + 32'h08, 32'd1);
        idle(500);
        rd(BASE + 32'h14);
        bus_req_i = 1; bus_we_i = 0; bus_addr_bi = BASE + 32'h10;
        rst_i = 1;
        m_seed = 0; m_steps = 0; m_started = 0; m_cleared = 1;
        exp_cyc.delete(); exp_dat.delete();
        #2;
        chk("rst_done_o", {31'd0, done_o}, 32'd0);
        chk("rst_resp",   {31'd0, bus_resp_o}, 32'd0);
        chk("rst_rdata",  bus_rdata_bo, 32'd0);
        chk("rst_ack",    {31'd0, bus_ack_o}, 32'd0);
        repeat (2) @(posedge clk_i);
        #1;
        bus_req_i = 0;
        rst_i = 0;
        rd_lit("post_status", BASE + 32'h0C, 32'd0);
        rd_lit("post_result", BASE + 32'h10, 32'd0);
        rd_lit("post_seed",   BASE + 32'h00, 32'd0);
        rd_lit("post_count",  BASE + 32'h14, 32'd0);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
